// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one byte-wide RAM port between instruction fetch (IF) and the data
// stage (MEM). Each granted access is split into byte cycles; read bytes are
// assembled little-endian and returned with a one-cycle done pulse.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              if_stall_request,
    output logic              mem_stall_request
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of byte cycles for a data access; the reserved length code
    // behaves like a word.
    function automatic logic [2:0] byte_count(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic              grant_if_s;
    logic              grant_mem_s;
    logic              last_s;
    logic              owner_mem_r;
    logic              we_r;
    logic [2:0]        n_r;
    logic [2:0]        cnt_r;
    logic [31:0]       wdata_r;
    logic [23:0]       rbuf_r;
    logic [31:0]       rdata_final_s;
    logic [ADDR_W-1:0] ram_addr_r;
    logic              ram_wr_r;
    logic [7:0]        ram_dout_r;
    logic              if_done_r;
    logic              mem_done_r;
    logic [31:0]       if_data_r;
    logic [31:0]       mem_rdata_r;

    assign if_data           = if_data_r;
    assign if_done           = if_done_r;
    assign mem_rdata         = mem_rdata_r;
    assign mem_done          = mem_done_r;
    assign ram_addr          = ram_addr_r;
    assign ram_wr            = ram_wr_r;
    assign ram_dout          = ram_dout_r;
    assign if_stall_request  = if_req & ~if_done_r;
    assign mem_stall_request = mem_req & ~mem_done_r;

    // Grant decision: only in IDLE, priority chosen by DATA_PRIO.
    always_comb begin
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (mem_req && ((DATA_PRIO == 1'b1) || !if_req)) begin
                grant_mem_s = 1'b1;
            end else if (if_req) begin
                grant_if_s = 1'b1;
            end else begin
                grant_if_s  = 1'b0;
                grant_mem_s = 1'b0;
            end
        end else begin
            grant_if_s  = 1'b0;
            grant_mem_s = 1'b0;
        end
    end

    // Last RUN cycle: writes end after N byte cycles, reads need one extra
    // cycle to catch the final byte coming back from the RAM.
    always_comb begin
        last_s = 1'b0;
        if (we_r) begin
            last_s = (cnt_r == (n_r - 3'd1));
        end else begin
            last_s = (cnt_r == n_r);
        end
    end

    // Final read word: earlier bytes from the buffer, last byte straight
    // from the RAM, unused upper bytes zero.
    always_comb begin
        rdata_final_s = 32'h0000_0000;
        case (n_r)
            3'd1:    rdata_final_s = {24'h00_0000, ram_din};
            3'd2:    rdata_final_s = {16'h0000, ram_din, rbuf_r[7:0]};
            default: rdata_final_s = {ram_din, rbuf_r};
        endcase
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_if_s || grant_mem_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Access context: latched at grant, then stepped once per RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_mem_r <= 1'b0;
            we_r        <= 1'b0;
            n_r         <= 3'd0;
            cnt_r       <= 3'd0;
            wdata_r     <= 32'h0000_0000;
            rbuf_r      <= 24'h00_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r  <= 3'd0;
                    rbuf_r <= 24'h00_0000;
                    if (grant_mem_s) begin
                        owner_mem_r <= 1'b1;
                        we_r        <= mem_we;
                        n_r         <= byte_count(mem_len);
                        // byte 0 goes straight to ram_dout; keep the rest
                        wdata_r     <= {8'h00, mem_wdata[31:8]};
                    end else if (grant_if_s) begin
                        owner_mem_r <= 1'b0;
                        we_r        <= 1'b0;
                        n_r         <= 3'd4;
                        wdata_r     <= 32'h0000_0000;
                    end else begin
                        wdata_r <= wdata_r;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + 3'd1;
                    if (we_r) begin
                        wdata_r <= {8'h00, wdata_r[31:8]};
                    end else begin
                        // byte k-1 arrives while the counter reads k
                        case (cnt_r)
                            3'd1:    rbuf_r[7:0]   <= ram_din;
                            3'd2:    rbuf_r[15:8]  <= ram_din;
                            3'd3:    rbuf_r[23:16] <= ram_din;
                            default: rbuf_r        <= rbuf_r;
                        endcase
                    end
                end
                default: begin
                    cnt_r <= 3'd0;
                end
            endcase
        end
    end

    // Registered RAM-side and requester-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wr_r    <= 1'b0;
            ram_dout_r  <= 8'h00;
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
            if_data_r   <= 32'h0000_0000;
            mem_rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if_done_r   <= 1'b0;
                    mem_done_r  <= 1'b0;
                    if_data_r   <= 32'h0000_0000;
                    mem_rdata_r <= 32'h0000_0000;
                    if (grant_mem_s) begin
                        ram_addr_r <= mem_addr;
                        ram_wr_r   <= mem_we;
                        ram_dout_r <= mem_we ? mem_wdata[7:0] : 8'h00;
                    end else if (grant_if_s) begin
                        ram_addr_r <= if_addr;
                        ram_wr_r   <= 1'b0;
                        ram_dout_r <= 8'h00;
                    end else begin
                        ram_addr_r <= {ADDR_W{1'b0}};
                        ram_wr_r   <= 1'b0;
                        ram_dout_r <= 8'h00;
                    end
                end
                ST_RUN: begin
                    if (last_s) begin
                        ram_addr_r  <= {ADDR_W{1'b0}};
                        ram_wr_r    <= 1'b0;
                        ram_dout_r  <= 8'h00;
                        if_done_r   <= ~owner_mem_r;
                        mem_done_r  <= owner_mem_r;
                        if_data_r   <= owner_mem_r ? 32'h0000_0000 : rdata_final_s;
                        mem_rdata_r <= (owner_mem_r && !we_r) ? rdata_final_s
                                                              : 32'h0000_0000;
                    end else begin
                        // address wraps naturally modulo 2^ADDR_W
                        ram_addr_r <= ram_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        ram_wr_r   <= we_r;
                        ram_dout_r <= we_r ? wdata_r[7:0] : 8'h00;
                    end
                end
                default: begin
                    ram_addr_r  <= {ADDR_W{1'b0}};
                    ram_wr_r    <= 1'b0;
                    ram_dout_r  <= 8'h00;
                    if_done_r   <= 1'b0;
                    mem_done_r  <= 1'b0;
                    if_data_r   <= 32'h0000_0000;
                    mem_rdata_r <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed and randomized accesses against a byte-RAM model; expected bus
// traffic, latency and read data come from a sequential access model.
module tb_mem_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam bit DATA_PRIO = 1'b1;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              if_stall_request;
    logic              mem_stall_request;

    int checks = 0;
    int errors = 0;

    // byte RAM decoding the low 12 address bits, plus a preload port
    logic [7:0]  ram [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;

    // access slots in service order
    bit          s_mem [2];
    bit          s_we [2];
    int          s_n [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wd [2];
    logic [31:0] s_exp [2];
    int          s_start [2];
    int          s_lat [2];
    int          ns;
    logic [31:0] last_if_data;
    logic [31:0] last_mem_rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_PRIO(DATA_PRIO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .if_stall_request(if_stall_request), .mem_stall_request(mem_stall_request)
    );

    always #5 clk = ~clk;

    // synchronous RAM: read data one cycle after the address
    always @(posedge clk) begin
        ram_din <= ram[ram_addr[11:0]];
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (ram_wr) begin
            ram[ram_addr[11:0]] <= ram_dout;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] r;
        logic [31:0] a;
        r = 32'h0;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            r = r | ({24'h0, ref_mem[a[11:0]]} << (8 * k));
        end
        return r;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a[11:0]; pre_data = d;
        ref_mem[a[11:0]] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Append an access to the service order and apply it to the model.
    task automatic add_slot(input bit is_mem, input bit we, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] a;
        s_mem[ns]  = is_mem;
        s_we[ns]   = is_mem & we;
        s_n[ns]    = !is_mem ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        s_addr[ns] = addr;
        s_wd[ns]   = wd;
        s_lat[ns]  = s_we[ns] ? s_n[ns] + 1 : s_n[ns] + 2;
        s_start[ns] = (ns == 0) ? 0 : s_start[ns-1] + s_lat[ns-1] + 1;
        s_exp[ns]  = s_we[ns] ? 32'h0 : ref_read(addr, s_n[ns]);
        if (s_we[ns]) begin
            for (int k = 0; k < s_n[ns]; k++) begin
                a = addr + k;
                ref_mem[a[11:0]] = wd[8*k +: 8];
            end
        end
        ns++;
    endtask

    // Issue requests at the current negedge and check every following cycle.
    task automatic run_acc(input bit use_if, input bit use_mem, input bit m_we,
                           input logic [1:0] m_len, input logic [31:0] m_addr,
                           input logic [31:0] m_wdata, input logic [31:0] i_addr,
                           input bit hold_mem);
        int endc;
        int k;
        bit exp_wr, exp_ifd, exp_memd;
        ns = 0;
        if (use_mem && (DATA_PRIO || !use_if)) begin
            add_slot(1'b1, m_we, m_len, m_addr, m_wdata);
            if (use_if) add_slot(1'b0, 1'b0, 2'd2, i_addr, 32'h0);
        end else begin
            if (use_if) add_slot(1'b0, 1'b0, 2'd2, i_addr, 32'h0);
            if (use_mem) add_slot(1'b1, m_we, m_len, m_addr, m_wdata);
        end
        endc = s_start[ns-1] + s_lat[ns-1];
        if_req = use_if; if_addr = i_addr;
        mem_req = use_mem; mem_we = m_we; mem_len = m_len;
        mem_addr = m_addr; mem_wdata = m_wdata;
        for (int c = 1; c <= endc; c++) begin
            @(negedge clk);
            exp_wr = 1'b0; exp_ifd = 1'b0; exp_memd = 1'b0;
            for (int s = 0; s < ns; s++) begin
                k = c - s_start[s] - 1;
                if (k >= 0 && k < s_n[s]) begin
                    chk("ram_addr", ram_addr, s_addr[s] + k);
                    if (s_we[s]) begin
                        exp_wr = 1'b1;
                        chk("ram_dout", {24'h0, ram_dout}, {24'h0, s_wd[s][8*k +: 8]});
                    end
                end
                if (c == s_start[s] + s_lat[s]) begin
                    if (s_mem[s]) begin
                        exp_memd = 1'b1;
                        last_mem_rdata = mem_rdata;
                        if (!s_we[s]) chk("mem_rdata", mem_rdata, s_exp[s]);
                    end else begin
                        exp_ifd = 1'b1;
                        last_if_data = if_data;
                        chk("if_data", if_data, s_exp[s]);
                    end
                end
            end
            chk("ram_wr", {31'h0, ram_wr}, {31'h0, exp_wr});
            chk("if_done", {31'h0, if_done}, {31'h0, exp_ifd});
            chk("mem_done", {31'h0, mem_done}, {31'h0, exp_memd});
            chk("if_stall", {31'h0, if_stall_request}, {31'h0, if_req & ~exp_ifd});
            chk("mem_stall", {31'h0, mem_stall_request}, {31'h0, mem_req & ~exp_memd});
            // disturb inputs of the access in service; then retire finished ones
            for (int s = 0; s < ns; s++) begin
                if (c == s_start[s] + 2) begin
                    if (s_mem[s]) begin
                        mem_addr = $urandom; mem_wdata = $urandom;
                        mem_len = 2'($urandom_range(0, 3)); mem_we = 1'($urandom_range(0, 1));
                    end else begin
                        if_addr = $urandom;
                    end
                end
                if (c == s_start[s] + s_lat[s]) begin
                    if (s_mem[s]) begin
                        if (hold_mem) begin
                            mem_addr = m_addr; mem_wdata = m_wdata;
                            mem_len = m_len; mem_we = m_we;
                        end else begin
                            mem_req = 1'b0;
                        end
                    end else begin
                        if_req = 1'b0;
                    end
                end
            end
        end
        if (!hold_mem) begin
            @(negedge clk);
            chk("if_done_pulse", {31'h0, if_done}, 32'h0);
            chk("mem_done_pulse", {31'h0, mem_done}, 32'h0);
            chk("ram_wr_idle", {31'h0, ram_wr}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] tmp;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rl;
        bit          rw;
        int          kind;
        rst = 1'b0; pre_we = 1'b0; pre_addr = 12'h0; pre_data = 8'h0;
        if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
        mem_len = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
        last_if_data = 32'h0; last_mem_rdata = 32'h0; ns = 0;

        // fill RAM and model while held in reset
        @(negedge clk);
        pre_we = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            tmp = i;
            pre_addr = tmp[11:0];
            pre_data = tmp[7:0] ^ tmp[11:4] ^ 8'h5A;
            ref_mem[i] = pre_data;
            @(negedge clk);
        end
        pre_we = 1'b0;
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
        chk("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
        chk("rst_if_done", {31'h0, if_done}, 32'h0);
        chk("rst_mem_done", {31'h0, mem_done}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // word fetch at 0x100
        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        @(negedge clk);
        run_acc(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h100, 1'b0);
        chk("fetch_word", last_if_data, 32'h4433_2211);

        // word store at 0x200, read back via IF
        @(negedge clk);
        run_acc(1'b0, 1'b1, 1'b1, 2'd2, 32'h200, 32'hA1B2_C3D4, 32'h0, 1'b0);
        @(negedge clk);
        run_acc(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h200, 1'b0);
        chk("store_readback", last_if_data, 32'hA1B2_C3D4);

        // simultaneous requests: MEM byte load first, IF after
        preload(32'h10, 8'h80);
        @(negedge clk);
        run_acc(1'b1, 1'b1, 1'b0, 2'd0, 32'h10, 32'h0, 32'h100, 1'b0);
        chk("contend_mem", last_mem_rdata, 32'h0000_0080);
        chk("contend_if", last_if_data, 32'h4433_2211);

        // half load across the address wrap
        preload(32'hFFFF_FFFF, 8'h3C); preload(32'h0, 8'hC3);
        @(negedge clk);
        run_acc(1'b0, 1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        chk("wrap_half", last_mem_rdata, 32'h0000_C33C);

        // reset during the third byte of a fetch, then restart
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) @(negedge clk);
        chk("pre_rst_addr", ram_addr, 32'h102);
        rst = 1'b0;
        #1;
        chk("abort_ram_addr", ram_addr, 32'h0);
        chk("abort_if_data", if_data, 32'h0);
        chk("abort_if_stall", {31'h0, if_stall_request}, 32'h1);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", {31'h0, if_done}, 32'h0);
        end
        rst = 1'b1;
        run_acc(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h100, 1'b0);
        chk("restart_fetch", last_if_data, 32'h4433_2211);

        // req held past done starts a second access
        @(negedge clk);
        run_acc(1'b0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        run_acc(1'b0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 32'h0, 1'b0);
        chk("held_second", last_mem_rdata, 32'h4433_2211);

        // randomized accesses
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            ra = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? ra : $urandom;
            rl = 2'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            tmp = $urandom;
            @(negedge clk);
            case (kind)
                0: run_acc(1'b1, 1'b0, 1'b0, rl, ra, tmp, rb, 1'b0);
                1: run_acc(1'b0, 1'b1, rw, rl, ra, tmp, rb, 1'b0);
                2: run_acc(1'b1, 1'b1, rw, rl, ra, tmp, rb, 1'b0);
                default: begin
                    run_acc(1'b0, 1'b1, rw, rl, ra, tmp, rb, 1'b1);
                    @(negedge clk);
                    run_acc(1'b0, 1'b1, rw, rl, ra, tmp, rb, 1'b0);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
